noc_path_arbiter: RTL and testbench

//  Round-robin arbiter granting point-to-point paths through the 2x2 mesh to processors P0..P3.

---
 rtl/noc_defs_pkg.sv | 35 +++
 rtl/rr_pick4.sv | 25 ++
 rtl/noc_path_arbiter.sv | 119 +++++++++++
 tb/tb_noc_path_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_defs_pkg.sv
// Shared definitions for the 2x2 mesh path arbiter: configure-word layout and command codes.
// Also used by the mesh path-block logic and the processor models.
package noc_defs;

    localparam int N_NODES = 4;
    localparam int LEN_W   = 7;
    localparam int IDX_W   = 2;
    localparam int CFG_W   = 11;

    localparam int CMD_HI  = 10;
    localparam int CMD_LO  = 9;
    localparam int LEN_HI  = 8;
    localparam int LEN_LO  = 2;
    localparam int DST_HI  = 1;
    localparam int DST_LO  = 0;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_OPEN  = 2'b01,
        CMD_CLOSE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    // Field order mirrors the configure word, so a plain cast decodes it.
    typedef struct packed {
        cmd_e             cmd;
        logic [LEN_W-1:0] len;
        logic [IDX_W-1:0] dst;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [CFG_W-1:0] word);
        return cfg_t'(word);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: the first set request at or after ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant_oh,
    output logic [1:0] grant_idx,
    output logic       grant_any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!grant_any && req[ptr + 2'(k)]) begin
                grant_any              = 1'b1;
                grant_idx              = ptr + 2'(k);
                grant_oh[ptr + 2'(k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_path_arbiter.sv
// Grants point-to-point mesh paths to P0..P3: one round-robin grant per cycle,
// per-destination ownership locks, explicit close and optional lease expiry.
module noc_path_arbiter
    import noc_defs::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CFG_W-1:0]     p0_configure,
    input  logic [CFG_W-1:0]     p1_configure,
    input  logic [CFG_W-1:0]     p2_configure,
    input  logic [CFG_W-1:0]     p3_configure,
    input  logic                 block_all_paths,
    output logic [N_NODES-1:0]   processor_ready_signals,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_src,
    output logic [IDX_W-1:0]     grant_dst,
    output logic [N_NODES-1:0]   dest_lock,
    output logic [2*N_NODES-1:0] dest_owner,
    output logic [N_NODES-1:0]   cfg_error
);

    cfg_t               req [N_NODES];
    logic [IDX_W-1:0]   owner [N_NODES];
    logic [LEN_W-1:0]   lease_cnt [N_NODES];

    logic [N_NODES-1:0] open_req, close_req, err_next, release_dst, ready_clear;
    logic [IDX_W-1:0]   rr_ptr, pick_idx, pick_dst;
    logic [N_NODES-1:0] pick_oh;
    logic               pick_any;

    assign req[0] = decode_cfg(p0_configure);
    assign req[1] = decode_cfg(p1_configure);
    assign req[2] = decode_cfg(p2_configure);
    assign req[3] = decode_cfg(p3_configure);

    assign dest_owner = {owner[3], owner[2], owner[1], owner[0]};
    assign pick_dst   = req[pick_idx].dst;

    // Everything here looks at pre-edge lock state, so a release and an open on
    // the same destination never meet in one cycle: the open waits a cycle.
    always_comb begin
        open_req    = '0;
        close_req   = '0;
        err_next    = '0;
        release_dst = '0;
        ready_clear = '0;
        for (int i = 0; i < N_NODES; i++) begin
            case (req[i].cmd)
                CMD_OPEN: begin
                    if (req[i].dst == IDX_W'(i))
                        err_next[i] = 1'b1;
                    else if (!block_all_paths && !dest_lock[req[i].dst] && !processor_ready_signals[i])
                        open_req[i] = 1'b1;
                end
                CMD_CLOSE: begin
                    if (processor_ready_signals[i])
                        close_req[i] = 1'b1;
                    else
                        err_next[i] = 1'b1;
                end
                CMD_RSVD: err_next[i] = 1'b1;
                default: ;
            endcase
        end
        for (int d = 0; d < N_NODES; d++) begin
            release_dst[d] = (lease_cnt[d] == LEN_W'(1)) || (dest_lock[d] && close_req[owner[d]]);
            if (release_dst[d])
                ready_clear[owner[d]] = 1'b1;
        end
    end

    rr_pick4 u_pick (
        .req       (open_req),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            processor_ready_signals <= '0;
            dest_lock               <= '0;
            grant_valid             <= 1'b0;
            grant_src               <= '0;
            grant_dst               <= '0;
            cfg_error               <= '0;
            rr_ptr                  <= '0;
            // NOTE: the small owner/lease arrays are reset too, since a reset must drop every live lease.
            for (int d = 0; d < N_NODES; d++) begin
                owner[d]     <= '0;
                lease_cnt[d] <= '0;
            end
        end else begin
            grant_valid             <= pick_any;
            grant_src               <= pick_any ? pick_idx : '0;
            grant_dst               <= pick_any ? pick_dst : '0;
            cfg_error               <= err_next;
            processor_ready_signals <= (processor_ready_signals & ~ready_clear) | pick_oh;
            for (int d = 0; d < N_NODES; d++) begin
                if (release_dst[d]) begin
                    dest_lock[d] <= 1'b0;
                    owner[d]     <= '0;
                    lease_cnt[d] <= '0;
                end else if (lease_cnt[d] != '0) begin
                    lease_cnt[d] <= lease_cnt[d] - 1'b1;
                end
            end
            // A granted destination was unlocked, so it never collides with a release above.
            if (pick_any) begin
                dest_lock[pick_dst] <= 1'b1;
                owner[pick_dst]     <= pick_idx;
                lease_cnt[pick_dst] <= req[pick_idx].len;
                rr_ptr              <= pick_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_path_arbiter.sv
// Self-checking bench for noc_path_arbiter: directed scenarios plus random traffic,
// compared every cycle against an ownership-table reference model.
module tb_noc_path_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] cfg [4];
    logic        block_all_paths;
    logic [3:0]  ready;
    logic        grant_valid;
    logic [1:0]  grant_src, grant_dst;
    logic [3:0]  dest_lock;
    logic [7:0]  dest_owner;
    logic [3:0]  cfg_error;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    noc_path_arbiter dut (
        .clock                   (clock),
        .reset                   (reset),
        .p0_configure            (cfg[0]),
        .p1_configure            (cfg[1]),
        .p2_configure            (cfg[2]),
        .p3_configure            (cfg[3]),
        .block_all_paths         (block_all_paths),
        .processor_ready_signals (ready),
        .grant_valid             (grant_valid),
        .grant_src               (grant_src),
        .grant_dst               (grant_dst),
        .dest_lock               (dest_lock),
        .dest_owner              (dest_owner),
        .cfg_error               (cfg_error)
    );

    // Reference state: which dest each processor holds, who holds each dest, lease left.
    int   m_own [4];
    int   m_holder [4];
    int   m_lease [4];
    int   m_ptr;
    logic m_gv;
    int   m_gs, m_gd;
    logic [3:0] m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [10:0] word(input int cmd, input int len, input int dst);
        return {2'(cmd), 7'(len), 2'(dst)};
    endfunction

    task automatic model_edge();
        int  cmd [4];
        int  len [4];
        int  dst [4];
        bit  elig [4];
        bit  rel [4];
        int  win;
        m_gv  = 1'b0;
        m_gs  = 0;
        m_gd  = 0;
        m_err = '0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_own[i] = -1; m_holder[i] = -1; m_lease[i] = 0;
            end
            m_ptr = 0;
            return;
        end
        for (int p = 0; p < 4; p++) begin
            cmd[p] = int'(cfg[p][10:9]);
            len[p] = int'(cfg[p][8:2]);
            dst[p] = int'(cfg[p][1:0]);
            if (cmd[p] == 3) m_err[p] = 1'b1;
            if (cmd[p] == 2 && m_own[p] < 0) m_err[p] = 1'b1;
            if (cmd[p] == 1 && dst[p] == p) m_err[p] = 1'b1;
            elig[p] = (cmd[p] == 1) && (dst[p] != p) && !block_all_paths
                      && (m_holder[dst[p]] < 0) && (m_own[p] < 0);
        end
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        for (int d = 0; d < 4; d++) begin
            rel[d] = 1'b0;
            if (m_lease[d] > 0) begin
                m_lease[d]--;
                rel[d] = (m_lease[d] == 0);
            end
        end
        for (int p = 0; p < 4; p++)
            if (cmd[p] == 2 && m_own[p] >= 0) rel[m_own[p]] = 1'b1;
        for (int d = 0; d < 4; d++)
            if (rel[d]) begin
                if (m_holder[d] >= 0) m_own[m_holder[d]] = -1;
                m_holder[d] = -1;
                m_lease[d]  = 0;
            end
        if (win >= 0) begin
            m_holder[dst[win]] = win;
            m_own[win]         = dst[win];
            m_lease[dst[win]]  = len[win];
            m_gv  = 1'b1;
            m_gs  = win;
            m_gd  = dst[win];
            m_ptr = (win + 1) % 4;
        end
    endtask

    task automatic compare_all();
        logic [3:0] er, el;
        logic [7:0] eo;
        for (int i = 0; i < 4; i++) begin
            er[i]       = (m_own[i] >= 0);
            el[i]       = (m_holder[i] >= 0);
            eo[2*i +: 2] = (m_holder[i] >= 0) ? 2'(m_holder[i]) : 2'd0;
        end
        check("ready", 32'(ready), 32'(er));
        check("dest_lock", 32'(dest_lock), 32'(el));
        check("dest_owner", 32'(dest_owner), 32'(eo));
        check("grant_valid", 32'(grant_valid), 32'(m_gv));
        check("cfg_error", 32'(cfg_error), 32'(m_err));
        if (m_gv) begin
            check("grant_src", 32'(grant_src), 32'(m_gs));
            check("grant_dst", 32'(grant_dst), 32'(m_gd));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic all_idle();
        for (int p = 0; p < 4; p++) cfg[p] = '0;
    endtask

    initial begin
        int r;
        reset           = 1'b1;
        block_all_paths = 1'b0;
        for (int p = 0; p < 4; p++) cfg[p] = 11'($urandom);

        // T1: reset with random words held
        step();
        for (int p = 0; p < 4; p++) cfg[p] = 11'($urandom);
        step();
        check("t1_ready", 32'(ready), 32'h0);
        check("t1_lock", 32'(dest_lock), 32'h0);
        check("t1_err", 32'(cfg_error), 32'h0);
        reset = 1'b0;
        all_idle();
        step();
        check("t1_owner_after", 32'(dest_owner), 32'h0);

        // T2: two opens in one cycle, pointer at 0
        cfg[2] = word(1, 0, 3);
        cfg[3] = word(1, 0, 1);
        step();
        check("t2_first_src", 32'(grant_src), 32'd2);
        check("t2_first_dst", 32'(grant_dst), 32'd3);
        step();
        check("t2_second_src", 32'(grant_src), 32'd3);
        check("t2_ready", 32'(ready), 32'b1100);
        check("t2_lock", 32'(dest_lock), 32'b1010);
        check("t2_owner", 32'(dest_owner), 32'b10_00_11_00);
        cfg[2] = word(2, 0, 0);
        cfg[3] = word(2, 0, 0);
        step();
        all_idle();
        step();

        // T3: contention for dst2
        cfg[0] = word(1, 0, 2);
        cfg[1] = word(1, 0, 2);
        step();
        check("t3_one_grant", 32'(grant_valid), 32'd1);
        check("t3_one_owner", 32'($countones(ready)), 32'd1);
        cfg[0] = '0;
        repeat (5) step();
        check("t3_loser_waits", 32'(ready[1]), 32'd0);
        cfg[0] = word(2, 0, 0);
        step();
        check("t3_no_same_cycle", 32'(grant_valid), 32'd0);
        cfg[0] = '0;
        step();
        check("t3_loser_gv", 32'(grant_valid), 32'd1);
        check("t3_loser_src", 32'(grant_src), 32'd1);
        check("t3_loser_dst", 32'(grant_dst), 32'd2);

        // T4: lease of 5 cycles on dst0
        cfg[1] = word(2, 0, 0);
        step();
        cfg[1] = word(1, 5, 0);
        step();
        check("t4_grant_src", 32'(grant_src), 32'd1);
        cfg[1] = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_lock_held", 32'(dest_lock[0]), 32'd1);
        end
        step();
        check("t4_lock_expired", 32'(dest_lock[0]), 32'd0);
        check("t4_ready_dropped", 32'(ready[1]), 32'd0);

        // T5: block_all_paths freezes grants only
        cfg[2] = word(1, 0, 1);
        step();
        cfg[2] = '0;
        block_all_paths = 1'b1;
        cfg[0] = word(1, 0, 3);
        repeat (50) begin
            step();
            check("t5_blocked", 32'(grant_valid), 32'd0);
            check("t5_path_kept", 32'(ready[2]), 32'd1);
        end
        block_all_paths = 1'b0;
        step();
        check("t5_release_gv", 32'(grant_valid), 32'd1);
        check("t5_release_src", 32'(grant_src), 32'd0);
        check("t5_release_dst", 32'(grant_dst), 32'd3);
        cfg[0] = '0;

        // T6: illegal words, held for two cycles
        cfg[2] = word(2, 0, 0);
        step();
        all_idle();
        step();
        cfg[1] = word(1, 0, 1);
        cfg[2] = word(2, 0, 0);
        cfg[3] = word(3, 0, 0);
        repeat (2) begin
            step();
            check("t6_err", 32'(cfg_error), 32'b1110);
            check("t6_lock", 32'(dest_lock), 32'b1000);
        end
        all_idle();
        step();
        check("t6_err_clear", 32'(cfg_error), 32'b0000);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 4; p++) begin
                r = int'($urandom_range(0, 99));
                if (r < 45) begin
                end else if (r < 65) begin
                    cfg[p] = word(1, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12)),
                                  int'($urandom_range(0, 3)));
                end else if (r < 78) begin
                    cfg[p] = word(2, 0, 0);
                end else if (r < 81) begin
                    cfg[p] = word(3, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
                end else begin
                    cfg[p] = '0;
                end
            end
            block_all_paths = ($urandom_range(0, 9) == 0);
            step();
        end

        // Reset mid-traffic drops all paths
        reset = 1'b1;
        step();
        check("end_rst_lock", 32'(dest_lock), 32'h0);
        reset = 1'b0;
        all_idle();
        block_all_paths = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
